// File: rtl/bf8b_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package bf8b_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam int INST_BYTES = 4;
  // Bytes per memory access; fetch addresses are aligned to this.
  localparam int MEM_ACC_32 = 4;

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH-entry {pc, inst} circular buffer with count, used by prefetch_queue.
module prefetch_fifo #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PC_W-1:0]            push_pc,
  input  logic [INST_W-1:0]          push_inst,
  output logic [PC_W-1:0]            head_pc,
  output logic [INST_W-1:0]          head_inst,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (clear) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr]   <= push_pc;
        inst_mem[wr_ptr] <= push_inst;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];
  assign count     = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: single-outstanding fetch FSM feeding a small FIFO.
// Optional same-cycle bypass of an empty queue: define PREFETCH_BYPASS_EN.
//
// state   | meaning
// IDLE    | no request outstanding (queue full)
// REQ     | request outstanding, response belongs to current stream
// DISCARD | request outstanding, response belongs to a flushed stream
module prefetch_queue
  import bf8b_pkg::*;
#(
  parameter int M_WIDTH    = 32,
  parameter int INST_WIDTH = INST_BYTES * 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [M_WIDTH-1:0]    flush_pc,
  input  logic [M_WIDTH-1:0]    mem_data_in,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic [M_WIDTH-1:0]    mem_addr,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [M_WIDTH-1:0]    pc_out,
  output logic                  valid,
  input  logic                  take
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CN_W  = CNT_W + 1;
  localparam logic [M_WIDTH-1:0] PC_STEP    = M_WIDTH'(INST_WIDTH / 8);
  localparam logic [M_WIDTH-1:0] ALIGN_MASK = ~M_WIDTH'(MEM_ACC_32 - 1);

  state_t             state, state_next;
  logic [M_WIDTH-1:0] fetch_pc, fetch_pc_next;
  logic [M_WIDTH-1:0] mem_addr_q, mem_addr_next;
  logic [M_WIDTH-1:0] flush_pc_aligned;
  logic [M_WIDTH-1:0]    head_pc;
  logic [INST_WIDTH-1:0] head_inst;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               resp_ok, bypass, push, pop, has_space;
  logic [CN_W-1:0]    count_next;

  assign flush_pc_aligned = flush_pc & ALIGN_MASK;
  assign resp_ok          = (state == REQ) & mem_ready & ~flush;

`ifdef PREFETCH_BYPASS_EN
  assign bypass = fifo_empty & resp_ok;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that decode takes in the same cycle never enters the queue.
  assign push       = resp_ok & ~(bypass & take) & ~fifo_full;
  assign pop        = take & ~fifo_empty;
  assign count_next = flush ? '0 : {1'b0, fifo_count} + CN_W'(push) - CN_W'(pop);
  assign has_space  = count_next < CN_W'(DEPTH);

  prefetch_fifo #(
    .DEPTH  (DEPTH),
    .PC_W   (M_WIDTH),
    .INST_W (INST_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .pop       (pop),
    .push_pc   (fetch_pc),
    .push_inst (mem_data_in[INST_WIDTH-1:0]),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fetch_pc   <= '0;
      mem_addr_q <= '0;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      mem_addr_q <= mem_addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    mem_addr_next = mem_addr_q;
    unique case (state)
      IDLE: begin
        if (flush) begin
          fetch_pc_next = flush_pc_aligned;
          mem_addr_next = flush_pc_aligned;
          state_next    = REQ;
        end else if (has_space) begin
          mem_addr_next = fetch_pc;
          state_next    = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          fetch_pc_next = flush_pc_aligned;
          // An in-flight request cannot be cancelled; wait it out in DISCARD.
          if (mem_ready) mem_addr_next = flush_pc_aligned;
          else           state_next    = DISCARD;
        end else if (mem_ready) begin
          fetch_pc_next = fetch_pc + PC_STEP;
          if (has_space) mem_addr_next = fetch_pc + PC_STEP;
          else           state_next    = IDLE;
        end
      end
      DISCARD: begin
        if (flush) fetch_pc_next = flush_pc_aligned;
        if (mem_ready) begin
          mem_addr_next = fetch_pc_next;
          state_next    = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_req  = (state != IDLE);
  assign mem_addr = mem_addr_q;
  assign valid    = ~fifo_empty | bypass;
  assign inst_out = bypass ? mem_data_in[INST_WIDTH-1:0] : head_inst;
  assign pc_out   = bypass ? mem_addr_q : head_pc;

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: directed scenarios plus random traffic vs a queue-based model.
module tb_prefetch_queue;

  localparam int DEPTH = 4;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, mem_ready, take;
  logic [31:0] flush_pc, mem_data_in;
  logic        mem_req, valid;
  logic [31:0] mem_addr, inst_out, pc_out;

  always #5 clk = ~clk;

  prefetch_queue #(.M_WIDTH(32), .INST_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .mem_data_in (mem_data_in),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .valid       (valid),
    .take        (take)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: buffered words, the outstanding request and the stream's next address.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t        q[$];
  bit          m_out, m_stale;
  logic [31:0] m_addr, m_next;
  int          age, lat;
  bit          rand_lat, data_is_addr, force_data_en;
  logic [31:0] forced_data;

  task automatic model_reset();
    q.delete();
    m_out = 0; m_stale = 0; m_addr = 0; m_next = 0; age = 0;
  endtask

  function automatic bit exp_bypass();
    return BYP && q.size() == 0 && m_out && !m_stale && mem_ready && !flush;
  endfunction

  task automatic model_update();
    bit resp, byp;
    if (rst) begin
      model_reset();
      return;
    end
    resp = m_out && mem_ready;
    byp  = exp_bypass();
    if (flush) begin
      q.delete();
      m_next = flush_pc & 32'hFFFF_FFFC;
    end else begin
      if (take && q.size() > 0) void'(q.pop_front());
      if (resp && !m_stale) begin
        if (!(byp && take)) q.push_back('{pc: m_addr, inst: mem_data_in});
        m_next = m_addr + 32'd4;
      end
    end
    if (m_out && !mem_ready) begin
      if (flush) m_stale = 1;
      age++;
    end else if (q.size() < DEPTH) begin
      m_out = 1; m_addr = m_next; m_stale = 0; age = 0;
      if (rand_lat) lat = $urandom_range(0, 3);
    end else begin
      m_out = 0;
    end
  endtask

  task automatic check_outputs();
    bit byp;
    byp = exp_bypass();
    check_eq("mem_req", 32'(mem_req), 32'(m_out));
    if (m_out) check_eq("mem_addr", mem_addr, m_addr);
    check_eq("valid", 32'(valid), 32'(q.size() > 0 || byp));
    if (q.size() > 0) begin
      check_eq("pc_out", pc_out, q[0].pc);
      check_eq("inst_out", inst_out, q[0].inst);
    end else if (byp) begin
      check_eq("byp_pc", pc_out, m_addr);
      check_eq("byp_inst", inst_out, mem_data_in);
    end
  endtask

  // rmode: 0 ready low, 1 ready high, 2 ready after the model's latency
  task automatic cycle(input bit r, input bit f, input logic [31:0] fp, input bit tk, input int rmode);
    rst = r; flush = f; flush_pc = fp; take = tk;
    case (rmode)
      0:       mem_ready = 1'b0;
      1:       mem_ready = 1'b1;
      default: mem_ready = m_out && (age >= lat);
    endcase
    mem_data_in = force_data_en ? forced_data : (data_is_addr ? m_addr : $urandom);
    #1 check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic quiet();
    rst = 0; flush = 0; take = 0; mem_ready = 0;
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
    check_eq({tag, "_valid"}, 32'(valid), 32'd0);
    check_eq({tag, "_pc_out"}, pc_out, 32'd0);
    check_eq({tag, "_inst_out"}, inst_out, 32'd0);
  endtask

  initial begin
    bit found;
    int take_pct;
    rst = 1; flush = 0; flush_pc = 0; mem_ready = 0; take = 0; mem_data_in = 0;
    lat = 2; rand_lat = 0; data_is_addr = 1; force_data_en = 0; forced_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    quiet();
    check_reset_values("reset");

    // Fill with take=0: requests 0,4,8,12 then stop.
    repeat (20) cycle(0, 0, 0, 0, 2);
    quiet();
    check_eq("full_mem_req", 32'(mem_req), 32'd0);
    check_eq("full_valid", 32'(valid), 32'd1);
    check_eq("full_head_pc", pc_out, 32'd0);
    check_eq("full_head_inst", inst_out, 32'd0);
    cycle(0, 0, 0, 1, 2);
    quiet();
    check_eq("pop_head_pc", pc_out, 32'd4);
    check_eq("pop_mem_req", 32'(mem_req), 32'd1);
    check_eq("pop_mem_addr", mem_addr, 32'd16);
    repeat (10) cycle(0, 0, 0, 0, 2);
    quiet();
    check_eq("refill_mem_req", 32'(mem_req), 32'd0);

    // Flush while the request to 8 is outstanding.
    cycle(1, 0, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle(0, 0, 0, 0, 2);
      quiet();
      found = (mem_req === 1'b1) && (mem_addr === 32'd8);
    end
    check_eq("wait_req8", 32'(found), 32'd1);
    cycle(0, 1, 32'h103, 0, 0);
    quiet();
    check_eq("flush_hold_req", 32'(mem_req), 32'd1);
    check_eq("flush_hold_addr", mem_addr, 32'd8);
    check_eq("flush_valid", 32'(valid), 32'd0);
    force_data_en = 1; forced_data = 32'hBAD0_BAD0;
    cycle(0, 0, 0, 0, 1);
    force_data_en = 0;
    quiet();
    check_eq("discard_valid", 32'(valid), 32'd0);
    check_eq("discard_next_addr", mem_addr, 32'h100);
    check_eq("discard_next_req", 32'(mem_req), 32'd1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(0, 0, 0, 0, 2);
      quiet();
      found = (valid === 1'b1);
    end
    check_eq("wait_flush_word", 32'(found), 32'd1);
    check_eq("flush_first_pc", pc_out, 32'h100);
    check_eq("flush_first_inst", inst_out, 32'h100);

    // Flush coincident with mem_ready and take.
    force_data_en = 1; forced_data = 32'h5555_AAAA;
    cycle(0, 1, 32'h200, 1, 1);
    force_data_en = 0;
    quiet();
    check_eq("flushrdy_valid", 32'(valid), 32'd0);
    check_eq("flushrdy_req", 32'(mem_req), 32'd1);
    check_eq("flushrdy_addr", mem_addr, 32'h200);
    cycle(0, 0, 0, 0, 0);
    quiet();
    check_eq("flushrdy_nowrite", 32'(valid), 32'd0);

    // Reset during REQ, then a stray mem_ready while IDLE.
    cycle(1, 0, 0, 0, 0);
    quiet();
    check_reset_values("midrst");
    cycle(0, 0, 0, 0, 1);
    quiet();
    check_eq("stray_valid", 32'(valid), 32'd0);
    check_eq("stray_req", 32'(mem_req), 32'd1);
    check_eq("stray_addr", mem_addr, 32'd0);

`ifdef PREFETCH_BYPASS_EN
    rst = 0; flush = 0; take = 0; mem_ready = 1; mem_data_in = 32'hDEAD_BEEF;
    #1;
    check_eq("byp_valid", 32'(valid), 32'd1);
    check_eq("byp_inst_out", inst_out, 32'hDEAD_BEEF);
    check_eq("byp_pc_out", pc_out, 32'd0);
    @(posedge clk); model_update(); #1;
    cycle(0, 0, 0, 1, 0);
    rst = 0; flush = 0; take = 1; mem_ready = 1; mem_data_in = 32'hCAFE_F00D;
    #1;
    check_eq("byptake_valid", 32'(valid), 32'd1);
    check_eq("byptake_inst", inst_out, 32'hCAFE_F00D);
    @(posedge clk); model_update(); #1;
    quiet();
    check_eq("byptake_empty", 32'(valid), 32'd0);
`endif

    // Random traffic with varying take pressure, flushes near address wrap, rare resets.
    rand_lat = 1; data_is_addr = 0;
    for (int p = 0; p < 4; p++) begin
      take_pct = 10 + p * 30;
      for (int n = 0; n < 1000; n++) begin
        logic [31:0] fp;
        fp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        cycle($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0, fp,
              $urandom_range(0, 99) < take_pct, 2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Instruction prefetch stage sitting between the memory interface arbiter (fetch client port) and decode, replacing the single-shot fetch unit. Keeps up to DEPTH sequential instruction words buffered with their PCs, issuing one memory request at a time while space remains. Decode pops words with a valid/take handshake. Execute redirects the stream with a flush carrying the new PC.

## Interface
- M_WIDTH, 32: data/address width in bits
- INST_WIDTH, 32: instruction width; INST_WIDTH/8 bytes added to the fetch PC per word
- DEPTH, 4: queue entries; power of two, at least 2
- clk  in  1  rising-edge clock
- rst  in  1  reset: one clock; reset is synchronous and active-high
- flush  in  1  one-cycle redirect pulse from execute
- flush_pc  in  M_WIDTH  new fetch byte address, sampled when flush=1
- mem_data_in  in  M_WIDTH  read data from memory interface, valid while mem_ready=1
- mem_ready  in  1  one-cycle completion of the outstanding request
- mem_req  out  1  request to memory interface; read-only client, 32-bit access
- mem_addr  out  M_WIDTH  byte address of the outstanding request; bits [1:0] always 0
- inst_out  out  INST_WIDTH  head instruction
- pc_out  out  M_WIDTH  byte address of the head instruction
- valid  out  1  head entry present
- take  in  1  decode pops the head; ignored when valid=0

## Operation
- Registers: fetch_pc (next address to request), count (0..DEPTH), rd/wr pointers, state.
- States: IDLE (no request outstanding), REQ (mem_req=1, waiting for mem_ready), DISCARD (mem_req=1, response belongs to a flushed stream).
- IDLE -> REQ when count + 0 < DEPTH. mem_addr <= fetch_pc.
- REQ on mem_ready: write {fetch_pc, mem_data_in} at wr pointer, fetch_pc += INST_WIDTH/8. Then REQ with the new address if space remains after this cycle's write/pop, else IDLE.
- Space check: count_next < DEPTH, where count_next = count + write - pop.
- Flush in any state:
  - Empties the queue (count=0, pointers equal) and sets fetch_pc = {flush_pc[M_WIDTH-1:2], 2'b00}.
  - From REQ without same-cycle mem_ready, go to DISCARD. mem_req and mem_addr are held; the memory interface cannot cancel a request.
  - From REQ with same-cycle mem_ready, drop the data and go to REQ at the flush address.
- DISCARD on mem_ready: drop the data; go to REQ at fetch_pc. A second flush in DISCARD only updates fetch_pc.
- Pop: when take and valid, advance the rd pointer. Simultaneous pop and write leave count unchanged.
- Flush beats take; flush beats write.
- fetch_pc wraps modulo 2^M_WIDTH.

## Timing
- Reset values: mem_req=0, mem_addr=0, valid=0, inst_out=0, pc_out=0, count=0, fetch_pc=0, state=IDLE. Storage is cleared.
- First cycle after rst deasserts: mem_req=1, mem_addr=0.
- mem_req and mem_addr are stable from assertion until the mem_ready cycle inclusive.
- Next request is driven in the cycle after mem_ready; no bubble is added by this block.
- Write to valid latency is 1 cycle: the entry is registered and visible the cycle after mem_ready.
- inst_out/pc_out are a combinational read of the head entry and hold while valid=1 and take=0.
- After flush: valid=0 in the next cycle. The first flushed-stream word appears no earlier than 1 cycle after its mem_ready.
- rst mid-request returns to reset values immediately. A late mem_ready after reset is ignored while in IDLE.

## Configuration
- PREFETCH_BYPASS_EN defined:
  - When count=0, state=REQ, mem_ready=1 and no flush: valid=1 combinationally in the same cycle, with inst_out=mem_data_in and pc_out=mem_addr.
  - If take is also 1, the word is consumed and not written.
  - Write-to-valid latency becomes 0.
- Undefined: no bypass path; latency is 1 cycle as above.

## Structure
- Package bf8b_pkg holds:
  - the state typedef (IDLE/REQ/DISCARD);
  - the INST_BYTES constant;
  - MEM_ACC_32, reused for the memory interface width field.
- One sub-module, prefetch_fifo:
  - DEPTH x {pc, inst} storage with pointers and count;
  - push/pop/clear inputs, full/empty outputs.
- prefetch_queue itself holds the request FSM and fetch_pc.

## Test plan
- Reset, memory responds 2 cycles after each request with word = address: requests at 0,4,8,12; with take=0, mem_req=0 after 4 fills; head pc_out=0, inst_out=0.
- Full queue, take=1 for one cycle: head becomes pc 4; exactly one new request at address 16 follows.
- Flush with flush_pc=0x103 while a request to 8 is outstanding: mem_req held until mem_ready; that data is dropped; next request is at 0x100; first valid entry has pc_out=0x100.
- Flush coincident with mem_ready and take: queue empty next cycle; next request is at the flush address; nothing written.
- rst asserted during REQ: all outputs return to reset values the next cycle; mem_ready then pulsed once creates no entry.
- With PREFETCH_BYPASS_EN, empty queue, mem_ready with data 0xDEADBEEF: valid=1 and inst_out=0xDEADBEEF in the same cycle; with take=1 the count stays 0.
